frame_bank_controller: RTL
==========================

FRAME_BANK_CONTROLLER -- requirements
Module: frame_bank_controller

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 76800, pixels per frame (320*240).
REQ-002 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-003 SHALL have port CLK25  input  1  25 MHz clock; the only clock.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cam_sof  input  1  1-cycle camera start-of-frame pulse; precedes first pixel.
REQ-006 SHALL have port cam_valid  input  1  camera pixel strobe.
REQ-007 SHALL have port vsync  input  1  display vertical sync, active low.
REQ-008 SHALL have port rd_enable  input  1  display active-pixel strobe.
REQ-009 SHALL have port wr_en  output  1  frame-buffer write enable.
REQ-010 SHALL have port wr_addr  output  ADDR_W  write address within bank.
REQ-011 SHALL have port wr_bank  output  1  bank being written.
REQ-012 SHALL have port rd_addr  output  ADDR_W  read address within bank.
REQ-013 SHALL have port rd_bank  output  1  bank being displayed.
REQ-014 SHALL have port frame_ready  output  1  completed frame awaiting swap.
REQ-015 SHALL have port swap_pulse  output  1  1-cycle pulse the cycle after a bank swap.
REQ-016 SHALL have port drop_cnt  output  8  camera frames dropped, saturating.

Function
REQ-017 SHALL implement writer FSM states W_IDLE, W_CAPTURE, W_DONE.
REQ-018 SHALL drive wr_bank = ~rd_bank combinationally at all times.
REQ-019 SHALL drive wr_en = cam_valid AND state==W_CAPTURE AND NOT cam_sof, combinationally.
REQ-020 W_IDLE: cam_sof -> W_CAPTURE, wr_addr <= 0; cam_valid ignored.
REQ-021 W_CAPTURE: each wr_en cycle increments wr_addr by 1; write at wr_addr==FRAME_PIXELS-1 -> W_DONE, wr_addr <= 0.
REQ-022 W_CAPTURE: cam_sof aborts partial frame, wr_addr <= 0, stays W_CAPTURE, drop_cnt unchanged.
REQ-023 W_DONE: cam_sof increments drop_cnt (saturate at 255); pixels ignored; state held.
REQ-024 SHALL register vsync into vsync_q; falling edge = vsync_q==1 AND vsync==0.
REQ-025 On falling edge with registered state==W_DONE: rd_bank toggles, writer -> W_IDLE, swap_pulse=1 next cycle.
REQ-026 On falling edge with state!=W_DONE: no swap; rd_bank and writer unchanged.
REQ-027 Final write (-> W_DONE) coinciding with falling edge SHALL NOT swap; swap waits for next falling edge.
REQ-028 cam_sof coinciding with swap SHALL be ignored (writer -> W_IDLE, drop_cnt unchanged).
REQ-029 While vsync==0, rd_addr SHALL be held at 0.
REQ-030 While vsync==1 and rd_enable==1, rd_addr SHALL increment, saturating at FRAME_PIXELS-1.
REQ-031 frame_ready SHALL equal (state==W_DONE), combinationally.
REQ-032 All address arithmetic ADDR_W bits unsigned; no wrap beyond FRAME_PIXELS-1.

Reset
REQ-033 On rst_i==1 at clock edge: state W_IDLE, wr_addr 0, rd_addr 0, rd_bank 0, drop_cnt 0, swap_pulse 0, vsync_q 1.
REQ-034 rst_i SHALL override all other inputs, including mid-capture and a coincident vsync edge.

Verification
REQ-035 Reset, cam_sof, 76800 cam_valid cycles -> wr_addr 0..76799 on bank 1, frame_ready=1 after last write, rd_bank=0.
REQ-036 frame_ready=1, vsync 1->0 -> rd_bank=1, wr_bank=0, swap_pulse one cycle, frame_ready=0.
REQ-037 W_DONE, three cam_sof pulses -> drop_cnt=3, wr_en stays 0; 300 pulses -> drop_cnt=255.
REQ-038 vsync high, 80000 rd_enable cycles -> rd_addr stops at 76799; vsync low -> rd_addr=0 next cycle.
REQ-039 Last write same cycle as vsync falling edge -> no swap, swap on following falling edge.
REQ-040 rst_i at wr_addr=1000 in W_CAPTURE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/frame_bank_controller.sv
// -----------------------------------------------------------------------------
// frame_bank_controller
//
// Double-buffered frame-buffer bank manager between a camera writer and a
// display reader. The camera fills the bank not being shown. A completed frame
// is held (frame_ready) until the display's vertical sync falls. At that point
// the banks swap and the writer is rearmed. Camera frames that arrive while a
// finished frame is still waiting are dropped and counted.
//
// Parameters
//   FRAME_PIXELS  pixels per frame (default 320*240)
//   ADDR_W        frame-buffer address width
//
// Ports
//   CLK25        in   25 MHz clock, the only clock
//   rst_i        in   synchronous active-high reset
//   cam_sof      in   1-cycle camera start-of-frame pulse
//   cam_valid    in   camera pixel strobe
//   vsync        in   display vertical sync, active low
//   rd_enable    in   display active-pixel strobe
//   wr_en        out  frame-buffer write enable
//   wr_addr      out  write address within the bank being written
//   wr_bank      out  bank being written (always opposite of rd_bank)
//   rd_addr      out  read address within the displayed bank
//   rd_bank      out  bank being displayed
//   frame_ready  out  a completed frame is waiting for a swap
//   swap_pulse   out  1-cycle pulse the cycle after a bank swap
//   drop_cnt     out  saturating count of dropped camera frames
// -----------------------------------------------------------------------------
module frame_bank_controller #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17
) (
  input  logic              CLK25,
  input  logic              rst_i,
  input  logic              cam_sof,
  input  logic              cam_valid,
  input  logic              vsync,
  input  logic              rd_enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic              swap_pulse,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_DONE    = 2'd2
  } wstate_t;

  wstate_t           state;
  wstate_t           state_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        drop_nxt;
  logic              vsync_q;
  logic              vsync_fall;
  logic              swap;

  assign vsync_fall  = vsync_q & ~vsync;
  // The swap qualifies on the registered state. A frame that completes in the
  // same cycle as the vsync edge therefore waits for the next edge.
  assign swap        = vsync_fall && (state == W_DONE);

  assign wr_bank     = ~rd_bank;
  assign wr_en       = cam_valid && (state == W_CAPTURE) && !cam_sof;
  assign frame_ready = (state == W_DONE);

  // Writer next-state. A swap takes priority over everything. As a result, a
  // start-of-frame that lands on the swap cycle is lost and not counted as a
  // drop.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    drop_nxt    = drop_cnt;
    if (swap) begin
      state_nxt   = W_IDLE;
      wr_addr_nxt = '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (cam_sof) begin
            state_nxt   = W_CAPTURE;
            wr_addr_nxt = '0;
          end
        end
        W_CAPTURE: begin
          if (cam_sof) begin
            wr_addr_nxt = '0;
          end else if (wr_en) begin
            if (wr_addr == LAST_ADDR) begin
              state_nxt   = W_DONE;
              wr_addr_nxt = '0;
            end else begin
              wr_addr_nxt = wr_addr + 1'b1;
            end
          end
        end
        W_DONE: begin
          if (cam_sof && (drop_cnt != 8'hFF)) begin
            drop_nxt = drop_cnt + 8'd1;
          end
        end
        default: begin
          state_nxt   = W_IDLE;
          wr_addr_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      state      <= W_IDLE;
      wr_addr    <= '0;
      drop_cnt   <= 8'd0;
      rd_bank    <= 1'b0;
      swap_pulse <= 1'b0;
      vsync_q    <= 1'b1;
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      drop_cnt   <= drop_nxt;
      rd_bank    <= rd_bank ^ swap;
      swap_pulse <= swap;
      vsync_q    <= vsync;
    end
  end

  // The read address is cleared during vertical blanking. During the active
  // display it advances on each active pixel and sticks at the last pixel
  // rather than wrapping.
  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      rd_addr <= '0;
    end else if (!vsync) begin
      rd_addr <= '0;
    end else if (rd_enable && (rd_addr != LAST_ADDR)) begin
      rd_addr <= rd_addr + 1'b1;
    end
  end

endmodule
